// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared ALU and memory port.
// Optional memory-wait watchdog is compiled in with `define MEM_TIMEOUT_EN.
module multicycle_sequencer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] opcode,
  input  logic       memReady,
  input  logic       branchTaken,
  output logic       instrReq,
  output logic       dataReq,
  output logic       dataWe,
  output logic       irWrite,
  output logic       pcWrite,
  output logic [1:0] pcSrc,
  output logic [1:0] ALUOp,
  output logic       ALUSrc,
  output logic       regWrite,
  output logic       memToReg,
  output logic       halted,
  output logic       fault,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BR, C_JAL, C_JALR, C_ILL
  } cls_t;

  state_t state_q, state_d;
  cls_t   cls_q;
  logic   timeout_hit;
  logic   mem_wait;

  function automatic cls_t classify(input logic [6:0] op);
    case (op)
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b0000011: return C_LOAD;
      7'b0100011: return C_STORE;
      7'b1100011: return C_BR;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      default:    return C_ILL;
    endcase
  endfunction

  // A request is outstanding and the memory has not answered this cycle.
  assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEM)) && !memReady;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] wait_q;
  logic          fault_q;

  assign timeout_hit = mem_wait && (wait_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      wait_q <= mem_wait ? wait_q + 1'b1 : '0;
      if (timeout_hit) fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0) ^ mem_wait;
  assign timeout_hit    = 1'b0;
  assign fault          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cls_q   <= C_ILL;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) cls_q <= classify(opcode);
    end
  end

  always_comb begin
    state_d  = state_q;
    instrReq = 1'b0;
    dataReq  = 1'b0;
    dataWe   = 1'b0;
    irWrite  = 1'b0;
    pcWrite  = 1'b0;
    pcSrc    = 2'b00;
    ALUOp    = 2'b00;
    ALUSrc   = 1'b0;
    regWrite = 1'b0;
    memToReg = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        instrReq = 1'b1;
        irWrite  = memReady;
        if (memReady)         state_d = S_DECODE;
        else if (timeout_hit) state_d = S_HALT;
      end
      S_DECODE: state_d = (classify(opcode) == C_ILL) ? S_HALT : S_EXEC;
      S_EXEC: begin
        case (cls_q)
          C_R: begin
            ALUOp   = 2'b10;
            state_d = S_WB;
          end
          C_I: begin
            ALUSrc  = 1'b1;
            state_d = S_WB;
          end
          C_LOAD, C_STORE: begin
            ALUSrc  = 1'b1;
            state_d = S_MEM;
          end
          C_BR: begin
            ALUOp   = 2'b01;
            pcWrite = 1'b1;
            pcSrc   = {1'b0, branchTaken};
            state_d = S_FETCH;
          end
          C_JAL, C_JALR: begin
            ALUOp   = 2'b11;
            ALUSrc  = 1'b1;
            state_d = S_WB;
          end
          default: state_d = S_HALT;
        endcase
      end
      // Address-phase ALU controls stay up for the whole data access.
      S_MEM: begin
        dataReq = 1'b1;
        dataWe  = (cls_q == C_STORE);
        ALUSrc  = 1'b1;
        if (memReady) begin
          if (cls_q == C_STORE) begin
            pcWrite = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_hit) begin
          state_d = S_HALT;
        end
      end
      S_WB: begin
        regWrite = 1'b1;
        pcWrite  = 1'b1;
        memToReg = (cls_q == C_LOAD) || (cls_q == C_JAL) || (cls_q == C_JALR);
        pcSrc    = (cls_q == C_JAL) ? 2'b01 : (cls_q == C_JALR) ? 2'b10 : 2'b00;
        state_d  = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: vector table, instruction-level trace model with random waits,
// and hand sequences for halt, reset mid-fetch and memory-wait timeout.
module tb_multicycle_sequencer;

  localparam int W  = 14;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, memReady, branchTaken;
  logic [6:0] opcode;
  logic       instrReq, dataReq, dataWe, irWrite, pcWrite, ALUSrc, regWrite, memToReg, halted, fault;
  logic [1:0] pcSrc, ALUOp;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       mr;
    logic [6:0] op;
    logic       bt;
    logic       st;
  } stim_t;

  typedef struct {
    logic [6:0] op;
    logic       taken;
    int         len;
    logic [1:0] ao;
    logic       as;
    logic [1:0] ps;
    logic       m2r;
    int         rw;
  } vec_t;

  stim_t        in_q[$];
  logic [W-1:0] exp_q[$];

  multicycle_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .memReady(memReady),
    .branchTaken(branchTaken), .instrReq(instrReq), .dataReq(dataReq), .dataWe(dataWe),
    .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .ALUOp(ALUOp), .ALUSrc(ALUSrc),
    .regWrite(regWrite), .memToReg(memToReg), .halted(halted), .fault(fault),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] cur();
    return {instrReq, dataReq, dataWe, irWrite, pcWrite, pcSrc, ALUOp, ALUSrc,
            regWrite, memToReg, halted, fault};
  endfunction

  function automatic logic [W-1:0] mk(input logic ir, input logic dr, input logic dw,
                                      input logic iw, input logic pw, input logic [1:0] ps,
                                      input logic [1:0] ao, input logic as, input logic rw,
                                      input logic m2r, input logic h, input logic f);
    return {ir, dr, dw, iw, pw, ps, ao, as, rw, m2r, h, f};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later, well before the rising edge.
  task automatic step(input logic mr, input logic [6:0] op, input logic bt, input logic st);
    @(negedge clk);
    memReady    = mr;
    opcode      = op;
    branchTaken = bt;
    start       = st;
    #1;
  endtask

  task automatic push(input logic mr, input logic [6:0] op, input logic bt, input logic [W-1:0] e);
    stim_t s;
    s.mr = mr; s.op = op; s.bt = bt; s.st = 1'($urandom);
    in_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // Expected cycle-by-cycle outputs for one instruction, derived from the instruction class rules.
  task automatic gen_instr(input logic [6:0] op, input int fw, input int mw, input logic taken);
    logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, legal;
    logic [1:0] ao;
    logic as;
    is_r    = (op == 7'b0110011);
    is_i    = (op == 7'b0010011);
    is_ld   = (op == 7'b0000011);
    is_st   = (op == 7'b0100011);
    is_br   = (op == 7'b1100011);
    is_jal  = (op == 7'b1101111);
    is_jalr = (op == 7'b1100111);
    legal   = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr;
    for (int i = 0; i < fw; i++)
      push(1'b0, 7'($urandom), 1'($urandom), mk(1,0,0,0,0,2'b00,2'b00,0,0,0,0,0));
    push(1'b1, 7'($urandom), 1'($urandom), mk(1,0,0,1,0,2'b00,2'b00,0,0,0,0,0));
    push(1'($urandom), op, 1'($urandom), '0);
    if (!legal) return;
    ao = is_r ? 2'b10 : is_br ? 2'b01 : (is_jal | is_jalr) ? 2'b11 : 2'b00;
    as = !(is_r | is_br);
    push(1'($urandom), op, taken, mk(0,0,0,0,is_br,{1'b0, is_br & taken},ao,as,0,0,0,0));
    if (is_ld | is_st) begin
      for (int i = 0; i < mw; i++)
        push(1'b0, op, 1'($urandom), mk(0,1,is_st,0,0,2'b00,2'b00,1,0,0,0,0));
      push(1'b1, op, 1'($urandom), mk(0,1,is_st,0,is_st,2'b00,2'b00,1,0,0,0,0));
    end
    if (!(is_st | is_br))
      push(1'($urandom), op, 1'($urandom),
           mk(0,0,0,0,1,{is_jalr, is_jal},2'b00,0,1,is_ld | is_jal | is_jalr,0,0));
  endtask

  task automatic run_q(input string name);
    stim_t s;
    logic [W-1:0] e;
    while (exp_q.size() > 0) begin
      s = in_q.pop_front();
      e = exp_q.pop_front();
      step(s.mr, s.op, s.bt, s.st);
      check(name, 32'(cur()), 32'(e));
    end
  endtask

  task automatic measure(input int idx, input vec_t v);
    int len, rw_n;
    bit done;
    logic [1:0] ps, ao;
    logic as, m2r;
    len = 0; rw_n = 0; done = 0; ps = 2'b00; ao = 2'b00; as = 1'b0; m2r = 1'b0;
    for (int c = 0; c < 12 && !done; c++) begin
      step(1'b1, v.op, v.taken, 1'b0);
      len++;
      if (c == 2) begin ao = ALUOp; as = ALUSrc; end
      if (regWrite) begin rw_n++; m2r = memToReg; end
      if (pcWrite) begin ps = pcSrc; done = 1; end
    end
    check($sformatf("vec%0d_retire", idx), 32'(done), 32'd1);
    check($sformatf("vec%0d_len", idx), len, v.len);
    check($sformatf("vec%0d_aluop", idx), 32'(ao), 32'(v.ao));
    check($sformatf("vec%0d_alusrc", idx), 32'(as), 32'(v.as));
    check($sformatf("vec%0d_pcsrc", idx), 32'(ps), 32'(v.ps));
    check($sformatf("vec%0d_memtoreg", idx), 32'(m2r), 32'(v.m2r));
    check($sformatf("vec%0d_regwrites", idx), rw_n, v.rw);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 7'd0, 1'b0, 1'b1);
    check("idle_start", 32'(cur()), 32'd0);
  endtask

  vec_t       tbl[8];
  logic [6:0] legal_ops[7];

  initial begin
    tbl[0] = '{7'b0110011, 1'b0, 4, 2'b10, 1'b0, 2'b00, 1'b0, 1};
    tbl[1] = '{7'b0010011, 1'b0, 4, 2'b00, 1'b1, 2'b00, 1'b0, 1};
    tbl[2] = '{7'b0000011, 1'b0, 5, 2'b00, 1'b1, 2'b00, 1'b1, 1};
    tbl[3] = '{7'b0100011, 1'b0, 4, 2'b00, 1'b1, 2'b00, 1'b0, 0};
    tbl[4] = '{7'b1100011, 1'b1, 3, 2'b01, 1'b0, 2'b01, 1'b0, 0};
    tbl[5] = '{7'b1100011, 1'b0, 3, 2'b01, 1'b0, 2'b00, 1'b0, 0};
    tbl[6] = '{7'b1101111, 1'b0, 4, 2'b11, 1'b1, 2'b01, 1'b1, 1};
    tbl[7] = '{7'b1100111, 1'b0, 4, 2'b11, 1'b1, 2'b10, 1'b1, 1};
    legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                  7'b1100011, 7'b1101111, 7'b1100111};

    rst_n = 1'b0; start = 1'b0; memReady = 1'b0; branchTaken = 1'b0; opcode = 7'd0;
    #12;
    check("reset_outputs", 32'(cur()), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 7'd0, 1'b0, 1'b0);
    check("idle_hold", 32'(cur()), 32'd0);
    check("idle_hold_state", 32'(state_dbg), 32'd0);
    step(1'b0, 7'd0, 1'b0, 1'b1);
    check("idle_start", 32'(cur()), 32'd0);

    // Zero-wait vector table: latency, ALU controls, pc source, writeback.
    for (int i = 0; i < 8; i++) measure(i, tbl[i]);

    // Back-to-back ALU op then randomized instruction stream with memory wait states.
    gen_instr(7'b0110011, 0, 0, 1'b0);
    gen_instr(7'b0000011, 0, 3, 1'b0);
    for (int n = 0; n < 60; n++)
      gen_instr(legal_ops[$urandom_range(0, 6)], $urandom_range(0, TO - 1),
                $urandom_range(0, TO - 1), 1'($urandom));
    run_q("trace");

    // Illegal opcode: HALT after DECODE and stays there.
    gen_instr(7'b0000000, 1, 0, 1'b0);
    for (int i = 0; i < 20; i++)
      push(1'($urandom), 7'($urandom), 1'($urandom), mk(0,0,0,0,0,2'b00,2'b00,0,0,0,1,0));
    run_q("halt");
    check("halt_state", 32'(state_dbg), 32'd6);

    // Reset asserted in the middle of a waiting fetch.
    do_reset();
    step(1'b0, 7'd0, 1'b0, 1'b0);
    check("fetch_req", 32'(instrReq), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_fetch_req", 32'(instrReq), 32'd0);
    check("rst_mid_fetch_out", 32'(cur()), 32'd0);
    check("rst_mid_fetch_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 7'd0, 1'b0, 1'b0);
    check("post_rst_idle", 32'(cur()), 32'd0);

    // Memory never answers during fetch.
    step(1'b0, 7'd0, 1'b0, 1'b1);
    check("idle_start2", 32'(cur()), 32'd0);
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < TO; i++)
      push(1'b0, 7'($urandom), 1'b0, mk(1,0,0,0,0,2'b00,2'b00,0,0,0,0,0));
    for (int i = 0; i < 5; i++)
      push(1'b0, 7'($urandom), 1'b0, mk(0,0,0,0,0,2'b00,2'b00,0,0,0,1,1));
`else
    for (int i = 0; i < 10; i++)
      push(1'b0, 7'($urandom), 1'b0, mk(1,0,0,0,0,2'b00,2'b00,0,0,0,0,0));
`endif
    run_q("stuck_fetch");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the single-issue RISC-V core; sequences fetch, decode, execute, memory and writeback over several cycles so one ALU and one memory port are shared.
- Sits between the opcode decoder and the datapath registers (PC, IR, regfile, memory port); drives per-state enables plus the ALU control fields used by the ALU decoder.
- Instruction and data memory use a simple req/ready handshake with arbitrary wait states.

Parameters:
- TIMEOUT_CYCLES, 255, max wait cycles on any memory request before fault (used only with MEM_TIMEOUT_EN).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  leave IDLE and begin fetching.
- opcode  input  7  IR[6:0], valid from DECODE onward.
- memReady  input  1  memory accepted/completed current request.
- branchTaken  input  1  branch comparison result, valid in EXEC.
- instrReq  output  1  instruction-fetch request.
- dataReq  output  1  data-memory request.
- dataWe  output  1  data request is a store.
- irWrite  output  1  latch fetched instruction into IR.
- pcWrite  output  1  update PC this cycle.
- pcSrc  output  2  00 pc+4, 01 branch/jal target, 10 jalr target.
- ALUOp  output  2  00 add/addr, 01 branch compare, 10 R-type funct, 11 link.
- ALUSrc  output  1  1 = immediate operand.
- regWrite  output  1  write rd this cycle.
- memToReg  output  1  1 = writeback from memory/link path.
- halted  output  1  in HALT state.
- fault  output  1  memory timeout fault (0 when MEM_TIMEOUT_EN undefined).

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Reset (async, rst_n=0) -> IDLE; all outputs 0.
- IDLE: stay until start=1 -> FETCH next cycle.
- FETCH: instrReq=1 held until memReady=1; irWrite=memReady (same cycle); on memReady -> DECODE.
- DECODE: 1 cycle; opcode classified. Illegal opcode (not 0110011,0010011,0000011,0100011,1100011,1100111,1101111) -> HALT; else -> EXEC.
- EXEC: 1 cycle; ALUOp/ALUSrc per class: R 10/0, I-ALU 00/1, load/store 00/1, branch 01/0, jal/jalr 11/1. Next: R/I-ALU -> WB; load/store -> MEM; branch -> FETCH with pcWrite=1, pcSrc=01 if branchTaken else 00; jal/jalr -> WB.
- MEM: dataReq=1, dataWe=1 for store, held with address-phase ALU controls until memReady=1. Load -> WB; store -> FETCH with pcWrite=1, pcSrc=00 in the memReady cycle.
- WB: 1 cycle; regWrite=1; memToReg=1 for load/jal/jalr; pcWrite=1, pcSrc=00 (R/I/load), 01 (jal), 10 (jalr); -> FETCH.
- Exactly one pcWrite pulse per retired instruction; regWrite never asserted outside WB.
- Zero-wait latencies: ALU 4 cycles, load 5, store 4, branch 3, jal/jalr 4.
- HALT: all enables 0, halted=1; exits only via reset.
- start ignored outside IDLE. memReady ignored outside FETCH/MEM.
- Reset mid-request: request drops immediately (async), no enable pulses, back to IDLE.

Optional Feature:
- MEM_TIMEOUT_EN defined: 8-bit-or-wider wait counter clears on entry to FETCH/MEM, increments each cycle with req high and memReady=0; reaching TIMEOUT_CYCLES -> HALT with fault=1, halted=1, request dropped.
- Undefined: no counter, waits forever, fault tied 0.

Test Plan:
- Reset, start=1, opcode=0110011, memReady always 1 -> instrReq cycle 1, irWrite cycle 1, regWrite+pcWrite(pcSrc=00) cycle 4, instrReq again cycle 5.
- Load 0000011, memReady low 3 cycles in MEM -> dataReq high 4 cycles, dataWe=0, then WB regWrite=1, memToReg=1; total 8 cycles.
- Branch 1100011 with branchTaken=1 then =0 -> pcWrite at EXEC with pcSrc=01 then 00; regWrite never 1.
- Store 0100011 -> dataReq=dataWe=1 one cycle, pcWrite in same cycle, regWrite 0; jalr 1100111 -> WB pcSrc=10, memToReg=1.
- opcode=0000000 -> HALT after DECODE, halted=1, no further instrReq for 20 cycles; rst_n low mid-FETCH -> instrReq=0 immediately, state IDLE.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, memReady stuck 0 in FETCH -> fault=1, halted=1 after 4 wait cycles, instrReq=0.
